// File: rtl/scratch_arbiter_if.sv
// Request/response bundle between the two scratch requesters, the clear
// command source and scratch_arbiter.
interface scratch_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              clr_req;
  logic              gnt_a;
  logic              gnt_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [CNT_W-1:0]  acc_cnt;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output clr_req,
    input  gnt_a, gnt_b, ack_a, ack_b, rdata, busy, acc_cnt
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  clr_req,
    output gnt_a, gnt_b, ack_a, ack_b, rdata, busy, acc_cnt
  );
endinterface

// File: rtl/scratch_arbiter.sv
// Two-port arbiter/sequencer owning a 4 x DATA_W scratch array, with clear sweep
// and access counter. Define SCRATCH_ARB_RR_EN for round-robin arbitration.
module scratch_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  scratch_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;
  localparam int DEPTH     = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [NUM_PORTS-1:0] req_vec;
  req_t [NUM_PORTS-1:0] req_in;
  logic                 win;

  logic [1:0]                    state_q, state_d;
  logic                          sel_q, sel_d;
  req_t                          cur_q, cur_d;
  logic [1:0]                    idx_q, idx_d;
  logic                          pend_q, pend_d;
  logic [NUM_PORTS-1:0]          gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;

  assign req_vec   = {bus.req_b, bus.req_a};
  assign req_in[0] = {bus.we_a, bus.addr_a, bus.wdata_a};
  assign req_in[1] = {bus.we_b, bus.addr_b, bus.wdata_b};

`ifdef SCRATCH_ARB_RR_EN
  // last_q holds the id of the most recent grant; reset to B so A goes first
  logic last_q, last_d;
  assign win = (&req_vec) ? ~last_q : req_vec[1];
`else
  assign win = ~req_vec[0];
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    gnt_d   = '0;
    ack_d   = '0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
`ifdef SCRATCH_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pend_q || bus.clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (|req_vec) begin
          sel_d      = win;
          cur_d      = req_in[win];
          gnt_d[win] = 1'b1;
          state_d    = S_ACCESS;
`ifdef SCRATCH_ARB_RR_EN
          last_d     = win;
`endif
        end
      end
      S_ACCESS: begin
        if (bus.clr_req) pend_d = 1'b1;
        if (cur_q.we) mem_d[cur_q.addr] = cur_q.wdata;
        else          rdata_d = mem_q[cur_q.addr];
        ack_d[sel_q] = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        state_d      = S_IDLE;
      end
      S_CLEAR: begin
        // pulses landing mid-sweep are absorbed by the sweep in progress
        if (bus.clr_req) pend_d = 1'b1;
        mem_d[idx_q] = '0;
        idx_d        = idx_q + 1'b1;
        if (idx_q == 2'd3) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      cur_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      mem_q   <= '0;
`ifdef SCRATCH_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
`ifdef SCRATCH_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.gnt_a   = gnt_q[0];
  assign bus.gnt_b   = gnt_q[1];
  assign bus.ack_a   = ack_q[0];
  assign bus.ack_b   = ack_q[1];
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.acc_cnt = cnt_q;
endmodule

// File: tb/tb_scratch_arbiter.sv
// Self-checking bench for scratch_arbiter against a transaction-level model
// of the scratch array, access counter and arbitration rule.
module tb_scratch_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scratch_arbiter_if bus ();
  scratch_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef SCRATCH_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] mm [4];
  logic [7:0]  mcnt;
  bit          last_win;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mm[i] = '0;
    mcnt     = '0;
    last_win = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.wdata_b = '0;
    bus.clr_req = 0;
  endtask

  // One access from an idle arbiter: gnt exactly one cycle later, ack the next.
  task automatic do_access(input bit port, input bit we, input logic [1:0] addr,
                           input logic [31:0] wdata, input bit clr_mid);
    logic [31:0] exp_rd;
    if (port == 0) begin
      bus.req_a = 1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
    end else begin
      bus.req_b = 1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
    end
    step();
    checks++;
    if ({bus.gnt_b, bus.gnt_a} !== (port ? 2'b10 : 2'b01) || bus.busy !== 1'b1 ||
        {bus.ack_b, bus.ack_a} !== 2'b00) begin
      errors++;
      $display("FAIL access_gnt: gnt_b/a=%b%b ack_b/a=%b%b busy=%b, want gnt port %0d busy 1",
               bus.gnt_b, bus.gnt_a, bus.ack_b, bus.ack_a, bus.busy, port);
    end
    bus.req_a = 0; bus.req_b = 0;
    if (clr_mid) bus.clr_req = 1;
    step();
    bus.clr_req = 0;
    mcnt++;
    last_win = port;
    exp_rd = mm[addr];
    if (we) mm[addr] = wdata;
    checks++;
    if ({bus.ack_b, bus.ack_a} !== (port ? 2'b10 : 2'b01) || {bus.gnt_b, bus.gnt_a} !== 2'b00 ||
        bus.acc_cnt !== mcnt || (!we && bus.rdata !== exp_rd)) begin
      errors++;
      $display("FAIL access_ack: ack_b/a=%b%b gnt_b/a=%b%b cnt=%0d rdata=%h, want port %0d cnt=%0d rdata=%h (we=%0d)",
               bus.ack_b, bus.ack_a, bus.gnt_b, bus.gnt_a, bus.acc_cnt, bus.rdata,
               port, mcnt, exp_rd, we);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    model_reset();
    checks++;
    if (bus.gnt_a !== 0 || bus.gnt_b !== 0 || bus.ack_a !== 0 || bus.ack_b !== 0 ||
        bus.busy !== 0 || bus.rdata !== 32'h0 || bus.acc_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b%b ack=%b%b busy=%b rdata=%h cnt=%0d, want all 0",
               bus.gnt_b, bus.gnt_a, bus.ack_b, bus.ack_a, bus.busy, bus.rdata, bus.acc_cnt);
    end
    reset = 0;
  endtask

  task automatic test_write_read();
    do_access(0, 1, 2'd2, 32'hDEADBEEF, 0);
    do_access(0, 0, 2'd2, 32'h0, 0);
    checks++;
    if (bus.rdata !== 32'hDEADBEEF || bus.acc_cnt !== 8'd2) begin
      errors++;
      $display("FAIL write_read: rdata=%h cnt=%0d, want deadbeef cnt=2", bus.rdata, bus.acc_cnt);
    end
  endtask

  // Back-to-back random single-port accesses at full throughput.
  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom, 0);
  endtask

  task automatic test_simultaneous();
    bit w;
    logic [1:0] aa, ab;
    aa = 2'($urandom_range(0, 3));
    ab = 2'($urandom_range(0, 3));
    w = 0;
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = aa;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = ab;
    for (int s = 1; s <= 8; s++) begin
      step();
      checks++;
      if (s % 2 == 1) begin
        w = RR ? ~last_win : 1'b0;
        last_win = w;
        if ({bus.gnt_b, bus.gnt_a} !== (w ? 2'b10 : 2'b01) || {bus.ack_b, bus.ack_a} !== 2'b00) begin
          errors++;
          $display("FAIL simul_gnt step %0d: gnt_b/a=%b%b ack_b/a=%b%b, want gnt port %0d",
                   s, bus.gnt_b, bus.gnt_a, bus.ack_b, bus.ack_a, w);
        end
      end else begin
        mcnt++;
        if ({bus.ack_b, bus.ack_a} !== (w ? 2'b10 : 2'b01) || {bus.gnt_b, bus.gnt_a} !== 2'b00 ||
            bus.acc_cnt !== mcnt || bus.rdata !== mm[w ? ab : aa]) begin
          errors++;
          $display("FAIL simul_ack step %0d: ack_b/a=%b%b gnt_b/a=%b%b cnt=%0d rdata=%h, want port %0d cnt=%0d rdata=%h",
                   s, bus.ack_b, bus.ack_a, bus.gnt_b, bus.gnt_a, bus.acc_cnt, bus.rdata,
                   w, mcnt, mm[w ? ab : aa]);
        end
      end
    end
    bus.req_a = 0; bus.req_b = 0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) do_access(0, 1, 2'(i), 32'h100 + $urandom_range(1, 1000), 0);
    bus.clr_req = 1;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 2'd0;
    for (int s = 1; s <= 6; s++) begin
      step();
      bus.clr_req = 0;
      checks++;
      if (bus.busy !== (s <= 4 || s == 6) || bus.gnt_b !== (s == 6) || bus.gnt_a !== 0) begin
        errors++;
        $display("FAIL clear_seq step %0d: busy=%b gnt_b=%b gnt_a=%b, want busy=%0d gnt_b=%0d",
                 s, bus.busy, bus.gnt_b, bus.gnt_a, (s <= 4 || s == 6), (s == 6));
      end
    end
    for (int i = 0; i < 4; i++) mm[i] = '0;
    bus.req_b = 0;
    step();
    mcnt++;
    last_win = 1;
    checks++;
    if (bus.ack_b !== 1 || bus.rdata !== 32'h0 || bus.acc_cnt !== mcnt) begin
      errors++;
      $display("FAIL clear_read0: ack_b=%b rdata=%h cnt=%0d, want 1 0 %0d",
               bus.ack_b, bus.rdata, bus.acc_cnt, mcnt);
    end
    for (int i = 1; i < 4; i++) do_access(1'(i % 2), 0, 2'(i), 32'h0, 0);
  endtask

  task automatic test_wrap_pending();
    while (mcnt != 8'd255)
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom | 32'h1, 0);
    do_access(0, 1, 2'd3, 32'h5A5A0001, 1);
    checks++;
    if (bus.acc_cnt !== 8'd0 || bus.busy !== 0) begin
      errors++;
      $display("FAIL cnt_wrap: cnt=%0d busy=%b, want 0 0", bus.acc_cnt, bus.busy);
    end
    for (int s = 1; s <= 6; s++) begin
      step();
      bus.clr_req = (s == 1);
      checks++;
      if (bus.busy !== (s <= 4)) begin
        errors++;
        $display("FAIL pending_sweep step %0d: busy=%b, want %0d", s, bus.busy, (s <= 4));
      end
    end
    bus.clr_req = 0;
    for (int i = 0; i < 4; i++) mm[i] = '0;
    do_access(1, 0, 2'd3, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    do_access(0, 1, 2'd3, 32'hA5A5A5A5, 0);
    do_access(0, 0, 2'd3, 32'h0, 0);
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 2'd1; bus.wdata_a = 32'h12345678;
    step();
    checks++;
    if (bus.gnt_a !== 1) begin
      errors++;
      $display("FAIL midrst_gnt: gnt_a=%b, want 1", bus.gnt_a);
    end
    bus.req_a = 0;
    reset = 1;
    step();
    checks++;
    if (bus.ack_a !== 0 || bus.ack_b !== 0 || bus.gnt_a !== 0 || bus.gnt_b !== 0 ||
        bus.busy !== 0 || bus.rdata !== 32'h0 || bus.acc_cnt !== 8'h0) begin
      errors++;
      $display("FAIL midrst_state: ack=%b%b gnt=%b%b busy=%b rdata=%h cnt=%0d, want all 0",
               bus.ack_b, bus.ack_a, bus.gnt_b, bus.gnt_a, bus.busy, bus.rdata, bus.acc_cnt);
    end
    reset = 0;
    model_reset();
    do_access(0, 0, 2'd1, 32'h0, 0);
    do_access(1, 0, 2'd3, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_simultaneous();
    test_clear();
    test_wrap_pending();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
